// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and mret, then
// drives flush -> CSR update strobe -> PC redirect. Option: TRAP_CTRL_VECTORED_EN.
module trap_ctrl #(
   parameter int unsigned FLUSH_TIMEOUT = 15,
   parameter int unsigned CNT_W         = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        exc_valid_i,
   input  logic [3:0]  exc_cause_i,
   input  logic [31:0] exc_tval_i,
   input  logic [31:0] pc_i,
   input  logic        mret_i,
   input  logic        int_meip_i,
   input  logic        int_mtip_i,
   input  logic        int_msip_i,
   input  logic        mstatus_mie_i,
   input  logic        mie_meie_i,
   input  logic        mie_mtie_i,
   input  logic        mie_msie_i,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mepc_i,
   input  logic        flush_ack_i,
   input  logic        redirect_ready_i,
   output logic        accept_o,
   output logic        busy_o,
   output logic        flush_o,
   output logic        trap_save_o,
   output logic        mret_restore_o,
   output logic [31:0] mepc_o,
   output logic [31:0] mcause_o,
   output logic [31:0] mtval_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   output logic        timeout_o
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_FLUSH    = 2'd1;
   localparam logic [1:0] S_UPDATE   = 2'd2;
   localparam logic [1:0] S_REDIRECT = 2'd3;

   // The exit test looks at the pre-increment count, so FLUSH lasts at most FLUSH_TIMEOUT cycles.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_TIMEOUT - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_trap_q, is_trap_d;
   logic             intr_q, intr_d;
   logic [3:0]       code_q, code_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      tval_q, tval_d;
   logic [31:0]      redir_pc_q, redir_pc_d;
   logic             timeout_q, timeout_d;

   logic       irq_any;
   logic [3:0] irq_code;
   logic       win;
   logic [31:0] trap_target;

   assign irq_any  = mstatus_mie_i & ((int_meip_i & mie_meie_i) | (int_msip_i & mie_msie_i) |
                                      (int_mtip_i & mie_mtie_i));
   assign irq_code = (int_meip_i & mie_meie_i) ? 4'd11 :
                     (int_msip_i & mie_msie_i) ? 4'd3  : 4'd7;
   assign win      = (state_q == S_IDLE) & (exc_valid_i | irq_any | mret_i);

`ifdef TRAP_CTRL_VECTORED_EN
   assign trap_target = (intr_q && mtvec_i[1:0] == 2'b01)
                      ? {mtvec_i[31:2], 2'b00} + {26'd0, code_q, 2'b00}
                      : {mtvec_i[31:2], 2'b00};
`else
   logic unused_mtvec_mode;
   assign unused_mtvec_mode = ^mtvec_i[1:0];
   assign trap_target       = {mtvec_i[31:2], 2'b00};
`endif

   always_comb begin
      // NOTE: every next-state variable gets its hold value first so no path infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_trap_d  = is_trap_q;
      intr_d     = intr_q;
      code_d     = code_q;
      pc_d       = pc_q;
      tval_d     = tval_q;
      redir_pc_d = redir_pc_q;
      timeout_d  = timeout_q;
      case (state_q)
         S_IDLE: begin
            if (win) begin
               state_d   = S_FLUSH;
               cnt_d     = '0;
               is_trap_d = exc_valid_i | irq_any;
               intr_d    = ~exc_valid_i & irq_any;
               code_d    = exc_valid_i ? exc_cause_i : (irq_any ? irq_code : 4'd0);
               pc_d      = pc_i;
               tval_d    = exc_tval_i;
            end
         end
         S_FLUSH: begin
            cnt_d = cnt_q + 1'b1;
            if (flush_ack_i) begin
               state_d = S_UPDATE;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = S_UPDATE;
               timeout_d = 1'b1;
            end
         end
         S_UPDATE: begin
            state_d    = S_REDIRECT;
            redir_pc_d = is_trap_q ? trap_target : mepc_i;
         end
         default: begin
            if (redirect_ready_i) state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         is_trap_q  <= 1'b0;
         intr_q     <= 1'b0;
         code_q     <= '0;
         pc_q       <= '0;
         tval_q     <= '0;
         redir_pc_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_trap_q  <= is_trap_d;
         intr_q     <= intr_d;
         code_q     <= code_d;
         pc_q       <= pc_d;
         tval_q     <= tval_d;
         redir_pc_q <= redir_pc_d;
         timeout_q  <= timeout_d;
      end
   end

   logic in_update, upd_trap;
   assign in_update = (state_q == S_UPDATE);
   assign upd_trap  = in_update & is_trap_q;

   assign accept_o         = win & ~rst_i;
   assign busy_o           = (state_q != S_IDLE);
   assign flush_o          = busy_o;
   assign trap_save_o      = upd_trap;
   assign mret_restore_o   = in_update & ~is_trap_q;
   assign mepc_o           = upd_trap ? {pc_q[31:2], 2'b00} : 32'd0;
   assign mcause_o         = upd_trap ? {intr_q, 27'd0, code_q} : 32'd0;
   assign mtval_o          = (!upd_trap || intr_q)            ? 32'd0  :
                             (code_q == 4'd4 || code_q == 4'd6) ? tval_q :
                             (code_q == 4'd0)                   ? pc_q   : 32'd0;
   assign redirect_valid_o = (state_q == S_REDIRECT);
   assign redirect_pc_o    = redirect_valid_o ? redir_pc_q : 32'd0;
   assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized and directed bench for trap_ctrl against a transaction-level reference model.
module tb_trap_ctrl;

   localparam int FLUSH_TO = 15;
`ifdef TRAP_CTRL_VECTORED_EN
   localparam bit VEC = 1'b1;
`else
   localparam bit VEC = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        exc_valid_i, mret_i;
   logic [3:0]  exc_cause_i;
   logic [31:0] exc_tval_i, pc_i, mtvec_i, mepc_i;
   logic        int_meip_i, int_mtip_i, int_msip_i;
   logic        mstatus_mie_i, mie_meie_i, mie_mtie_i, mie_msie_i;
   logic        flush_ack_i, redirect_ready_i;
   logic        accept_o, busy_o, flush_o, trap_save_o, mret_restore_o;
   logic [31:0] mepc_o, mcause_o, mtval_o, redirect_pc_o;
   logic        redirect_valid_o, timeout_o;

   int n_checks = 0;
   int n_fail   = 0;
   bit timeout_exp = 1'b0;

   always #5 clk_i = ~clk_i;

   trap_ctrl #(.FLUSH_TIMEOUT(15), .CNT_W(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_tval_i(exc_tval_i),
      .pc_i(pc_i), .mret_i(mret_i),
      .int_meip_i(int_meip_i), .int_mtip_i(int_mtip_i), .int_msip_i(int_msip_i),
      .mstatus_mie_i(mstatus_mie_i), .mie_meie_i(mie_meie_i), .mie_mtie_i(mie_mtie_i),
      .mie_msie_i(mie_msie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
      .flush_ack_i(flush_ack_i), .redirect_ready_i(redirect_ready_i),
      .accept_o(accept_o), .busy_o(busy_o), .flush_o(flush_o),
      .trap_save_o(trap_save_o), .mret_restore_o(mret_restore_o),
      .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .timeout_o(timeout_o)
   );

   typedef struct {
      bit         valid;
      bit         trap;
      bit         intr;
      logic [3:0] code;
   } arb_t;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Priority list walk: exception, then MEI/MSI/MTI, then mret.
   function automatic arb_t arbitrate();
      arb_t a;
      int   prio_code [3];
      bit   prio_hit  [3];
      a = '{default: 0};
      prio_code = '{11, 3, 7};
      prio_hit  = '{int_meip_i & mie_meie_i, int_msip_i & mie_msie_i, int_mtip_i & mie_mtie_i};
      if (exc_valid_i) begin
         a.valid = 1; a.trap = 1; a.code = exc_cause_i;
         return a;
      end
      if (mstatus_mie_i) begin
         for (int i = 0; i < 3; i++) begin
            if (prio_hit[i]) begin
               a.valid = 1; a.trap = 1; a.intr = 1; a.code = 4'(prio_code[i]);
               return a;
            end
         end
      end
      if (mret_i) a.valid = 1;
      return a;
   endfunction

   task automatic clear_reqs();
      exc_valid_i = 0; mret_i = 0; mstatus_mie_i = 0;
      int_meip_i = 0; int_mtip_i = 0; int_msip_i = 0;
      flush_ack_i = 0; redirect_ready_i = 0;
   endtask

   // Runs one sequence from the currently driven IDLE inputs; ack_delay >= FLUSH_TO means never.
   task automatic run_seq(input int ack_delay, input int ready_delay, input logic [31:0] mepc_val);
      arb_t        a;
      logic [31:0] cap_pc, cap_tval, exp_mtval, exp_target, exp_cause;
      int          n_flush;
      #1;
      a = arbitrate();
      if (!a.valid) begin
         check("idle_no_accept", {31'd0, accept_o}, 32'd0);
         tick();
         return;
      end
      cap_pc   = pc_i;
      cap_tval = exc_tval_i;
      check("accept", {31'd0, accept_o}, 32'd1);
      check("idle_busy", {31'd0, busy_o}, 32'd0);
      exp_cause = a.trap ? ((a.intr ? 32'h8000_0000 : 32'd0) + 32'(a.code)) : 32'd0;
      if (!a.trap || a.intr)              exp_mtval = 0;
      else if (a.code == 4 || a.code == 6) exp_mtval = cap_tval;
      else if (a.code == 0)               exp_mtval = cap_pc;
      else                                exp_mtval = 0;
      if (a.trap)
         exp_target = (mtvec_i & ~32'd3) +
                      ((VEC && a.intr && mtvec_i[1:0] == 2'b01) ? 32'(a.code) * 4 : 0);
      else
         exp_target = mepc_val;
      tick();
      // Scramble everything except mtvec: captured values must not move.
      exc_valid_i = 0; mret_i = 0;
      exc_cause_i = 4'($urandom); exc_tval_i = $urandom; pc_i = $urandom;
      {int_meip_i, int_mtip_i, int_msip_i} = 3'($urandom);
      mstatus_mie_i = 1'($urandom);
      n_flush = (ack_delay < FLUSH_TO) ? ack_delay + 1 : FLUSH_TO;
      for (int k = 0; k < n_flush; k++) begin
         flush_ack_i = (k == ack_delay);
         #1;
         check("flush_o", {31'd0, flush_o}, 32'd1);
         check("flush_no_accept", {31'd0, accept_o}, 32'd0);
         check("flush_no_strobe", {30'd0, trap_save_o, mret_restore_o}, 32'd0);
         tick();
      end
      flush_ack_i = 0;
      mepc_i = mepc_val;
      #1;
      check("upd_trap_save", {31'd0, trap_save_o}, {31'd0, a.trap});
      check("upd_mret_restore", {31'd0, mret_restore_o}, {31'd0, ~a.trap});
      check("upd_mepc", mepc_o, a.trap ? (cap_pc & ~32'd3) : 32'd0);
      check("upd_mcause", mcause_o, exp_cause);
      check("upd_mtval", mtval_o, exp_mtval);
      check("upd_flush", {31'd0, flush_o}, 32'd1);
      check("upd_no_redirect", {31'd0, redirect_valid_o}, 32'd0);
      tick();
      mepc_i = $urandom;
      for (int r = 0; r <= ready_delay; r++) begin
         redirect_ready_i = (r == ready_delay);
         #1;
         check("redir_valid", {31'd0, redirect_valid_o}, 32'd1);
         check("redir_pc", redirect_pc_o, exp_target);
         check("redir_no_strobe", {30'd0, trap_save_o, mret_restore_o}, 32'd0);
         tick();
      end
      clear_reqs();
      if (ack_delay >= FLUSH_TO) timeout_exp = 1'b1;
      #1;
      check("done_busy", {31'd0, busy_o}, 32'd0);
      check("done_redirect", {31'd0, redirect_valid_o}, 32'd0);
      check("timeout_o", {31'd0, timeout_o}, {31'd0, timeout_exp});
   endtask

   task automatic zero_inputs();
      clear_reqs();
      exc_cause_i = 0; exc_tval_i = 0; pc_i = 0; mtvec_i = 0; mepc_i = 0;
      mie_meie_i = 0; mie_mtie_i = 0; mie_msie_i = 0;
   endtask

   task automatic random_seq();
      exc_valid_i = ($urandom_range(0, 3) == 0);
      exc_cause_i = 4'($urandom);
      exc_tval_i  = $urandom;
      pc_i        = $urandom;
      mret_i      = ($urandom_range(0, 2) == 0);
      {int_meip_i, int_mtip_i, int_msip_i} = 3'($urandom);
      {mie_meie_i, mie_mtie_i, mie_msie_i} = 3'($urandom);
      mstatus_mie_i = 1'($urandom);
      mtvec_i     = $urandom;
      run_seq($urandom_range(0, 16), $urandom_range(0, 3), $urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      zero_inputs();
      rst_i = 1;
      tick();
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_flush", {31'd0, flush_o}, 32'd0);
      check("rst_timeout", {31'd0, timeout_o}, 32'd0);
      check("rst_strobes", {29'd0, trap_save_o, mret_restore_o, redirect_valid_o}, 32'd0);
      rst_i = 0;
      tick();

      // Illegal instruction, ack in the fourth FLUSH cycle.
      exc_valid_i = 1; exc_cause_i = 2; pc_i = 32'h104; mtvec_i = 32'h200;
      run_seq(3, 0, 32'h0);
      // Load address misaligned.
      exc_valid_i = 1; exc_cause_i = 4; exc_tval_i = 32'h1003; pc_i = 32'h40;
      run_seq(0, 1, 32'h0);
      // All interrupts pending and enabled, vectored mtvec.
      {int_meip_i, int_mtip_i, int_msip_i} = 3'b111;
      {mie_meie_i, mie_mtie_i, mie_msie_i} = 3'b111;
      mstatus_mie_i = 1; mtvec_i = 32'h201; pc_i = 32'h88;
      run_seq(1, 0, 32'h0);
      // Exception and mret together: trap first, then mret alone.
      exc_valid_i = 1; mret_i = 1; exc_cause_i = 1; pc_i = 32'h500; mtvec_i = 32'h200;
      run_seq(0, 0, 32'h0);
      mret_i = 1;
      run_seq(2, 2, 32'h300);

      repeat (15) random_seq();

      // Watchdog expiry, then sticky across later sequences.
      exc_valid_i = 1; exc_cause_i = 0; pc_i = 32'h7F2; mtvec_i = 32'h400;
      run_seq(FLUSH_TO + 5, 0, 32'h0);
      check("timeout_set", {31'd0, timeout_o}, 32'd1);
      repeat (15) random_seq();

      // Asynchronous reset in the middle of FLUSH.
      exc_valid_i = 1; exc_cause_i = 5; pc_i = 32'h900;
      #1;
      check("pre_rst_accept", {31'd0, accept_o}, 32'd1);
      tick();
      exc_valid_i = 0;
      tick();
      #2;
      rst_i = 1;
      #1;
      check("rst_async_flush", {31'd0, flush_o}, 32'd0);
      check("rst_async_busy", {31'd0, busy_o}, 32'd0);
      timeout_exp = 1'b0;
      tick();
      rst_i = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         check("post_rst_quiet", {29'd0, trap_save_o, mret_restore_o, busy_o}, 32'd0);
         tick();
      end
      check("post_rst_timeout", {31'd0, timeout_o}, {31'd0, timeout_exp});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer placed between the core pipeline and the CSR file.
- Arbitrates among synchronous exceptions, pending M-mode interrupts (external, software, timer) and mret.
- Drains the pipeline with a flush handshake, issues one-cycle CSR update strobes (trap save or mret restore), then issues a PC redirect.
- The CSR file holds the architectural state; this block only sequences updates to it.

Parameters:
- FLUSH_TIMEOUT, 15: maximum number of cycles spent in FLUSH waiting for flush_ack_i before proceeding anyway.
- CNT_W, 4: width of the flush watchdog counter. Must satisfy 2^CNT_W > FLUSH_TIMEOUT.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- exc_valid_i  in  1  exception request (level); core holds it until accept_o.
- exc_cause_i  in  4  exception code.
- exc_tval_i  in  32  faulting address for misaligned load/store.
- pc_i  in  32  PC of the instruction being trapped or interrupted.
- mret_i  in  1  mret request (level); held until accept_o.
- int_meip_i, int_mtip_i, int_msip_i  in  1 each  raw interrupt pending lines.
- mstatus_mie_i  in  1  global interrupt enable from the CSR file.
- mie_meie_i, mie_mtie_i, mie_msie_i  in  1 each  per-source interrupt enables.
- mtvec_i  in  32  trap vector: base in [31:2], mode in [1:0].
- mepc_i  in  32  return address from the CSR file.
- flush_ack_i  in  1  pipeline reports it has drained.
- redirect_ready_i  in  1  fetch unit accepts the redirect.
- accept_o  out  1  one-cycle pulse: request captured.
- busy_o  out  1  high when state is not IDLE.
- flush_o  out  1  pipeline flush request.
- trap_save_o  out  1  one-cycle strobe: CSR file loads mepc/mcause/mtval and sets mpie<=mie, mie<=0.
- mret_restore_o  out  1  one-cycle strobe: CSR file sets mie<=mpie, mpie<=1.
- mepc_o  out  32  value to load into mepc.
- mcause_o  out  32  value to load into mcause.
- mtval_o  out  32  value to load into mtval.
- redirect_valid_o  out  1  redirect request.
- redirect_pc_o  out  32  redirect target.
- timeout_o  out  1  sticky flag: a flush watchdog expiry has occurred.

Behaviour:
- Reset: state IDLE; all outputs and internal registers 0, applied immediately (asynchronous). Reset mid-sequence abandons the sequence; no strobe is issued afterwards.
- States: IDLE -> FLUSH -> UPDATE -> REDIRECT -> IDLE.
- IDLE arbitration, evaluated every cycle, highest priority first:
  - exc_valid_i.
  - Enabled interrupt, i.e. mstatus_mie_i & (ip & ie) is non-zero. Source priority is MEI (code 11), then MSI (code 3), then MTI (code 7).
  - mret_i.
- On a win:
  - accept_o pulses for one cycle.
  - Kind (trap or ret), cause, pc_i and tval are captured.
  - State moves to FLUSH on the next edge.
  - Inputs that change after capture do not affect the sequence.
- Requests arriving outside IDLE are not captured; the requester keeps holding them.
- FLUSH:
  - flush_o=1; the watchdog counter starts at 0 and increments each cycle.
  - Exit to UPDATE when flush_ack_i=1, or when count==FLUSH_TIMEOUT.
  - On a timeout exit, timeout_o is set; it is cleared only by reset.
- UPDATE: exactly one cycle, flush_o stays 1.
  - Trap: trap_save_o=1.
  - mepc_o={pc[31:2],2'b00}.
  - mcause_o={interrupt_flag,27'b0,code[3:0]}.
  - mtval_o = captured tval for exception codes 4 or 6; = pc for code 0; = 0 otherwise, and always 0 for interrupts.
  - Ret: mret_restore_o=1; mepc_o, mcause_o and mtval_o are 0.
- REDIRECT:
  - flush_o=1 and redirect_valid_o=1; redirect_pc_o is held stable.
  - On redirect_ready_i=1: all outputs drop and state returns to IDLE. The earliest new accept is the following cycle.
  - Trap target: {mtvec_i[31:2],2'b00}.
  - Ret target: mepc_i as sampled in UPDATE.
- Strobes trap_save_o and mret_restore_o never assert in the same cycle, and never more than once per sequence.
- Minimum latency, accept to redirect_valid_o: 3 cycles (flush_ack_i already high).

Optional Feature:
- Macro: TRAP_CTRL_VECTORED_EN.
- Defined: if mtvec_i[1:0]==2'b01 and the trap is an interrupt, redirect_pc_o={mtvec_i[31:2],2'b00}+4*code. Exceptions and modes 2 and 3 use direct mode.
- Undefined: mtvec_i[1:0] is ignored and every trap uses direct mode.

Test Plan:
- Illegal instruction:
  - Stimulus: exc cause 2, pc 0x104, mtvec 0x200, flush_ack_i after 3 FLUSH cycles.
  - Response: accept_o pulse; trap_save_o with mepc 0x104, mcause 0x2, mtval 0; then redirect 0x200.
- Load misaligned:
  - Stimulus: cause 4, tval 0x1003, pc 0x40.
  - Response: mtval_o 0x1003, mepc_o 0x40.
- All three interrupts pending and enabled, mie=1, mtvec 0x201:
  - Response: mcause_o 0x8000000B; redirect 0x22C with the macro, 0x200 without.
- exc_valid_i and mret_i together in the same IDLE cycle:
  - Response: trap sequence runs first, no mret_restore_o.
  - After the redirect, mret alone with mepc_i 0x300: mret_restore_o pulse, redirect 0x300.
- flush_ack_i held 0:
  - Response: exit after 15 FLUSH cycles; timeout_o=1 and stays 1 through later sequences.
- rst_i asserted in FLUSH:
  - Response: flush_o and busy_o go to 0 without waiting for a clock edge; state IDLE; no strobe after release.
